bist_misr_analyzer: RTL

//  Response compactor downstream of the BIST datapath. Consumes the 16-bit pattern stream driven to the LEDs
//  (ring / johnson / LFSR) and folds it into a 16-bit multiple-input signature register (MISR) over a fixed window.
//  At the end of the window it compares the signature against a per-mode golden value and reports pass/fail.

---
 rtl/bist_pkg.sv | 25 ++
 rtl/bist_misr_analyzer_if.sv | 31 +++
 rtl/bist_misr_core.sv | 34 +++
 rtl/bist_misr_analyzer.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared encodings and default constants for the BIST response-analysis blocks.
package bist_pkg;

    typedef enum logic [1:0] {
        MODE_NONE = 2'b00,
        MODE_RING = 2'b01,
        MODE_JOHN = 2'b10,
        MODE_LFSR = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // x^16 + x^12 + x^5 + 1, Galois form
    localparam logic [15:0] DEFAULT_POLY = 16'h1021;
    localparam logic [15:0] DEFAULT_SEED = 16'h0000;

    function automatic logic mode_active(input logic [1:0] m);
        return m != MODE_NONE;
    endfunction

endpackage

// File: rtl/bist_misr_analyzer_if.sv
// Bus between the BIST datapath/controller side (master) and the MISR analyzer (slave).
interface bist_misr_analyzer_if #(
    parameter int WINDOW = 16
) ();
    localparam int CW = $clog2(WINDOW + 1);

    // pattern_valid has no ready: the analyzer consumes pattern_in on every clock where
    // pattern_valid is high while busy; outside a run the sample is dropped.
    logic                  start;
    logic [1:0]            mode;
    logic                  pattern_valid;
    logic [15:0]           pattern_in;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [15:0]           signature;
    logic [CW-1:0]         sample_cnt;
    bist_pkg::state_t      state;
    logic [1:0]            mode_q;

    modport master (
        output start, mode, pattern_valid, pattern_in,
        input  busy, done, pass, signature, sample_cnt, state, mode_q
    );

    modport slave (
        input  start, mode, pattern_valid, pattern_in,
        output busy, done, pass, signature, sample_cnt, state, mode_q
    );

endinterface

// File: rtl/bist_misr_core.sv
// 16-bit Galois multiple-input signature register; pure datapath with seed load and enable.
module bist_misr_core #(
    parameter logic [15:0] SEED = 16'h0000,
    parameter logic [15:0] POLY = 16'h1021
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        enable,
    input  logic [15:0] data_in,
    output logic [15:0] signature,
    output logic [15:0] sig_next
);

    logic [15:0] sig_q;

    always_comb begin
        sig_next = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ data_in;
    end

    // clear wins over enable so a new run always starts from SEED
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sig_q <= SEED;
        end else if (clear) begin
            sig_q <= SEED;
        end else if (enable) begin
            sig_q <= sig_next;
        end
    end

    assign signature = sig_q;

endmodule

// File: rtl/bist_misr_analyzer.sv
// MISR response analyzer: run FSM, sample counter, golden mux and compare.
// Optional BIST_MISR_AUTORUN_EN: back-to-back runs with a sticky-low pass flag.
module bist_misr_analyzer
    import bist_pkg::*;
#(
    parameter int          WINDOW      = 16,
    parameter logic [15:0] SEED        = DEFAULT_SEED,
    parameter logic [15:0] POLY        = DEFAULT_POLY,
    parameter logic [15:0] GOLDEN_RING = 16'h0000,
    parameter logic [15:0] GOLDEN_JOHN = 16'h0000,
    parameter logic [15:0] GOLDEN_LFSR = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    bist_misr_analyzer_if.slave  bus
);

    localparam int CW = $clog2(WINDOW + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(WINDOW - 1);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    mode_q;
    logic          pass_q;
`ifdef BIST_MISR_AUTORUN_EN
    logic          fail_q;
`endif

    logic          start_ok;
    logic          load_seed;
    logic          take;
    logic          last;
    logic          match;
    logic [15:0]   golden;
    logic [15:0]   sig;
    logic [15:0]   sig_next;

    assign start_ok = bus.start && mode_active(bus.mode);
    assign take     = (state_q == ST_RUN) && bus.pattern_valid;
    assign last     = take && (cnt_q == LAST_IDX);
    assign match    = (sig_next == golden);

    always_comb begin
        golden = 16'h0000;
        case (mode_q)
            MODE_RING: golden = GOLDEN_RING;
            MODE_JOHN: golden = GOLDEN_JOHN;
            MODE_LFSR: golden = GOLDEN_LFSR;
            default:   golden = 16'h0000;
        endcase
    end

    always_comb begin
        load_seed = 1'b0;
        if (state_q != ST_RUN && start_ok) begin
            load_seed = 1'b1;
        end
`ifdef BIST_MISR_AUTORUN_EN
        if (state_q == ST_DONE) begin
            load_seed = 1'b1;
        end
`endif
    end

    bist_misr_core #(
        .SEED (SEED),
        .POLY (POLY)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .clear     (load_seed),
        .enable    (take),
        .data_in   (bus.pattern_in),
        .signature (sig),
        .sig_next  (sig_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_NONE;
            pass_q  <= 1'b0;
`ifdef BIST_MISR_AUTORUN_EN
            fail_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_ok) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                        mode_q  <= bus.mode;
                        pass_q  <= 1'b0;
`ifdef BIST_MISR_AUTORUN_EN
                        fail_q  <= 1'b0;
`endif
                    end
                end
                ST_RUN: begin
                    if (take) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                    // pass is decided on the signature the last sample produces
                    if (last) begin
                        state_q <= ST_DONE;
`ifdef BIST_MISR_AUTORUN_EN
                        pass_q  <= match && !fail_q;
                        fail_q  <= fail_q || !match;
`else
                        pass_q  <= match;
`endif
                    end
                end
                ST_DONE: begin
                    if (start_ok) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                        mode_q  <= bus.mode;
                        pass_q  <= 1'b0;
`ifdef BIST_MISR_AUTORUN_EN
                        fail_q  <= 1'b0;
`endif
                    end
`ifdef BIST_MISR_AUTORUN_EN
                    else begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                        pass_q  <= 1'b0;
                    end
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = (state_q == ST_RUN);
    assign bus.done       = (state_q == ST_DONE);
    assign bus.pass       = pass_q;
    assign bus.signature  = sig;
    assign bus.sample_cnt = cnt_q;
    assign bus.state      = state_q;
    assign bus.mode_q     = mode_q;

endmodule
